// File: rtl/wait_sum_collector.sv
// rtl/wait_sum_collector.sv - one-sample-per-episode capture of W into a FWFT FIFO with debug counters
module wait_sum_collector #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_load,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              empty,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sample_cnt,
  output logic [ACC_W-1:0]  drop_cnt,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ARMED, HELD} state_t;

  state_t             state_q, state_d;
  logic               capture;
  logic               pop;
  logic               push_ok;
  logic               drop;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [ACC_W-1:0]   acc_q, sample_cnt_q, drop_cnt_q;
  logic               overflow_q;

  // Capture FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARMED;
    else       state_q <= state_d;
  end

  // Capture FSM next state: one capture on the first high cycle of each w_load episode
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ARMED: begin
        if (w_load) begin
          capture = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!w_load) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a capture when the head leaves in the same cycle
  assign pop     = out_valid & out_ready;
  assign push_ok = capture & (!full | pop);
  assign drop    = capture & full & !pop;

  // FIFO storage; contents are meaningless while empty, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= w_in;
  end

  // FIFO pointers and occupancy; pointer width makes the modulo-DEPTH wrap implicit
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  // Debug accounting: totals follow accepted samples, drop count saturates, overflow is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        acc_q        <= acc_q + ACC_W'(w_in);
        sample_cnt_q <= sample_cnt_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign acc        = acc_q;
  assign sample_cnt = sample_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_wait_sum_collector.sv
// tb/tb_wait_sum_collector.sv - directed self-checking bench for wait_sum_collector
module tb_wait_sum_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] w_in;
  logic       w_load;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       empty;
  logic [7:0] acc;
  logic [7:0] sample_cnt;
  logic [7:0] drop_cnt;
  logic       overflow;

  int checks = 0;
  int fails  = 0;

  wait_sum_collector #(.DATA_W(4), .DEPTH(4), .ACC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_in      (w_in),
    .w_load    (w_load),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .acc       (acc),
    .sample_cnt(sample_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic episode(input logic [3:0] v);
    w_in   = v;
    w_load = 1'b1;
    tick();
    w_load = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; w_in = '0; w_load = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", out_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;

    // 1: capture on load
    w_in = 4'd5; w_load = 1'b1;
    #1;
    check("t1_valid_before", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 5);
    check("t1_acc", acc, 5);
    check("t1_cnt", sample_cnt, 1);
    tick(); tick(); tick();
    w_load = 1'b0;
    tick();
    check("t1_cnt_hold", sample_cnt, 1);
    check("t1_acc_hold", acc, 5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_single_entry", empty, 1);

    // 2: fill and drop (fresh reset so totals start at zero)
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    episode(4'd1); episode(4'd2); episode(4'd3);
    check("t2_not_full", full, 0);
    episode(4'd4);
    check("t2_full", full, 1);
    check("t2_acc4", acc, 10);
    check("t2_cnt4", sample_cnt, 4);
    check("t2_ovf_pre", overflow, 0);
    episode(4'd9);
    check("t2_drop", drop_cnt, 1);
    check("t2_ovf", overflow, 1);
    check("t2_acc", acc, 10);
    check("t2_cnt", sample_cnt, 4);
    check("t2_full_after", full, 1);

    // 3: drain order
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_data", out_data, i);
      tick();
    end
    out_ready = 1'b0;
    check("t3_empty", empty, 1);
    check("t3_valid", out_valid, 0);
    check("t3_ovf", overflow, 1);

    // 4: push and pop while full
    episode(4'd1); episode(4'd2); episode(4'd3); episode(4'd4);
    check("t4_full_pre", full, 1);
    check("t4_acc_pre", acc, 20);
    w_in = 4'd7; w_load = 1'b1; out_ready = 1'b1;
    #1;
    check("t4_head", out_data, 1);
    tick();
    w_load = 1'b0; out_ready = 1'b0;
    check("t4_full", full, 1);
    check("t4_drop", drop_cnt, 1);
    check("t4_acc", acc, 27);
    check("t4_cnt", sample_cnt, 9);
    tick();
    out_ready = 1'b1;
    check("t4_d0", out_data, 2); tick();
    check("t4_d1", out_data, 3); tick();
    check("t4_d2", out_data, 4); tick();
    check("t4_d3", out_data, 7); tick();
    out_ready = 1'b0;
    check("t4_empty", empty, 1);

    // 5: back-to-back episodes, w_load 1,1,0,1
    w_in = 4'd6; w_load = 1'b1; tick();
    w_in = 4'd8; tick();
    w_load = 1'b0; tick();
    w_load = 1'b1; tick();
    w_load = 1'b0; tick();
    check("t5_cnt", sample_cnt, 11);
    check("t5_acc", acc, 41);
    out_ready = 1'b1;
    check("t5_d0", out_data, 6); tick();
    check("t5_d1", out_data, 8); tick();
    out_ready = 1'b0;
    check("t5_empty", empty, 1);

    // 6: reset mid-operation with w_load high
    episode(4'd2); episode(4'd3);
    check("t6_cnt_pre", sample_cnt, 13);
    check("t6_valid_pre", out_valid, 1);
    w_in = 4'd5; w_load = 1'b1; reset = 1'b1;
    tick();
    check("t6_rst_empty", empty, 1);
    check("t6_rst_acc", acc, 0);
    check("t6_rst_cnt", sample_cnt, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_drop", drop_cnt, 0);
    reset = 1'b0;
    tick();
    check("t6_cnt", sample_cnt, 1);
    check("t6_acc", acc, 5);
    check("t6_valid", out_valid, 1);
    check("t6_data", out_data, 5);
    w_load = 1'b0; tick();

    // 6 extra: accumulator wrap, draining continuously
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) episode(4'd15);
    check("t6_acc_prewrap", acc, 245);
    episode(4'd15);
    check("t6_acc_wrap", acc, 4);
    check("t6_cnt_wrap", sample_cnt, 18);
    check("t6_drop_wrap", drop_cnt, 0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/wait_sum_collector.md
Name: wait_sum_collector

Overview:
- Downstream consumer of the dual-counter wait stage.
- Takes the 4-bit sum W and its load indication `w_load`, which is held high while both counters are stopped.
- Captures exactly one sample per load episode into a small first-word-fall-through FIFO and presents samples over a valid/ready interface.
- Keeps a running total, an accepted-sample count and overflow/drop status for debug readout.

Parameters:
- DATA_W, 4, width of the W sample.
- DEPTH, 4, FIFO depth in entries; power of two, at least 2.
- ACC_W, 8, width of the running total and of both counters.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- w_in  input  DATA_W  sum value from the upstream stage.
- w_load  input  1  level; high while upstream holds a valid sum.
- out_data  output  DATA_W  head-of-FIFO sample.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- acc  output  ACC_W  sum of all accepted samples, modulo 2^ACC_W.
- sample_cnt  output  ACC_W  number of accepted samples, wraps.
- drop_cnt  output  ACC_W  number of dropped captures, saturates at all-ones.
- overflow  output  1  sticky; set on the first drop.

Behaviour:
- Reset (reset, synchronous, active-high; clock clk):
  - Capture FSM goes to ARMED.
  - FIFO pointers and occupancy go to 0; empty=1, full=0, out_valid=0.
  - acc, sample_cnt, drop_cnt and overflow go to 0.
  - out_data is don't-care while empty.
  - Reset mid-operation discards all FIFO contents. If w_load is high at reset release, it is captured on the first cycle after release, because ARMED sees w_load=1.
- Capture FSM, two states:
  - ARMED: w_load=1 raises a capture in this cycle and moves to HELD; otherwise stays ARMED.
  - HELD: no capture. w_load=0 moves to ARMED; w_load=1 stays HELD.
  - Result: one capture per contiguous high episode of w_load, sampled on the first high cycle. A one-cycle low gap between two high episodes gives two captures.
- Push/pop:
  - pop = out_valid & out_ready.
  - push_ok = capture & (!full | pop).
  - On push_ok, w_in is written at the write pointer; the write pointer increments modulo DEPTH.
  - On pop, the read pointer increments modulo DEPTH.
  - Occupancy: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop while full: both occur and full stays 1.
  - Capture while empty: the pop side is idle that cycle because out_valid=0.
  - out_data = mem[rd_ptr] combinationally. Latency from capture to out_valid is 1 cycle: out_valid rises the cycle after the capture edge.
- Drop:
  - Condition: capture & full & !pop.
  - Effects: sample discarded; overflow is set and stays set until reset; drop_cnt increments, saturating.
  - acc and sample_cnt do not change.
- Accounting, on push_ok only:
  - acc ← acc + zero-extended w_in, wrapping modulo 2^ACC_W.
  - sample_cnt ← sample_cnt + 1, wrapping.
- full and empty are registered-state-derived: full = (occupancy == DEPTH), empty = (occupancy == 0).
- All outputs except out_data are glitch-free registered values or direct decodes of registered state.

Test Plan:
1. Capture on load:
   - Stimulus: reset 2 cycles, out_ready=0; w_in=5, w_load high for 4 cycles then low.
   - Response: exactly one entry; out_valid=1 from the cycle after w_load rises; out_data=5; acc=5; sample_cnt=1.
2. Fill and drop:
   - Stimulus: out_ready=0; five load episodes with w_in=1,2,3,4,9, separated by low gaps.
   - Response: full=1 after the fourth; the fifth is dropped; overflow=1; drop_cnt=1; acc=10; sample_cnt=4.
3. Drain order:
   - Stimulus: continue from scenario 2, out_ready=1 for 4 cycles.
   - Response: out_data 1,2,3,4 in order; empty=1 afterwards; overflow stays 1.
4. Push and pop while full:
   - Stimulus: FIFO full with 1,2,3,4; a capture of w_in=7 in the same cycle as out_ready=1.
   - Response: 1 popped and 7 accepted; full stays 1; no drop; acc increases by 7.
5. Back-to-back episodes:
   - Stimulus: w_load pattern 1,1,0,1 with w_in=6 then 8.
   - Response: two captures (6 and 8); a steady-high w_load produces no extra captures.
6. Reset mid-operation:
   - Stimulus: two entries stored, then reset pulsed while w_load=1.
   - Response: FIFO empty and all counters 0; one capture occurs on the first cycle after release; sample_cnt=1.
   - Extra check: acc wraps to w_in−(256−prior) when the total exceeds 255.
